// File: rtl/snes_pad_emulator_pkg.sv
// Shared constants for the SNES pad emulator: FSM encodings, frame size,
// button bit positions and the 25 MHz protocol delays shared with the reader.
package snes_pad_emulator_pkg;

  localparam int unsigned SNES_NBITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned FILT_CNT_W = 4;

  // One-hot FSM encodings
  localparam logic [3:0] ST_IDLE     = 4'b0001;
  localparam logic [3:0] ST_LOADED   = 4'b0010;
  localparam logic [3:0] ST_SHIFTING = 4'b0100;
  localparam logic [3:0] ST_DONE     = 4'b1000;

  localparam int unsigned BTN_B     = 0;
  localparam int unsigned BTN_Y     = 1;
  localparam int unsigned BTN_SEL   = 2;
  localparam int unsigned BTN_START = 3;
  localparam int unsigned BTN_UP    = 4;
  localparam int unsigned BTN_DOWN  = 5;
  localparam int unsigned BTN_LEFT  = 6;
  localparam int unsigned BTN_RIGHT = 7;
  localparam int unsigned BTN_A     = 8;
  localparam int unsigned BTN_X     = 9;
  localparam int unsigned BTN_L     = 10;
  localparam int unsigned BTN_R     = 11;

  localparam int unsigned DLY_6US  = 150;
  localparam int unsigned DLY_12US = 300;

endpackage

// File: rtl/snes_pad_if.sv
// SNES controller wire bundle: host drives latch/clock, pad drives data.
interface snes_pad_if;
  logic snes_latch;
  logic snes_clk;
  logic snes_data;

  modport master (output snes_latch, output snes_clk, input  snes_data);
  modport slave  (input  snes_latch, input  snes_clk, output snes_data);
endinterface

// File: rtl/snes_input_filter.sv
// Synchroniser plus stability filter for one asynchronous protocol pin;
// emits the accepted level and single-cycle rise/fall pulses.
module snes_input_filter
  import snes_pad_emulator_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LVL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // A new level is accepted on its FILT_LEN-th consecutive differing sample
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_out != level_q) begin
      if (cnt_q == FILT_CNT_W'(FILT_LEN - 1)) begin
        level_d = sync_out;
        rise_d  = sync_out;
        fall_d  = ~sync_out;
      end else begin
        cnt_d = cnt_q + FILT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{IDLE_LVL}};
      cnt_q   <= '0;
      level_q <= IDLE_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/snes_pad_emulator.sv
// Device-side SNES pad: captures btn_in while latch is high and shifts it out
// active-low on filtered clock rises.
module snes_pad_emulator
  import snes_pad_emulator_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_25M,
  input  logic                  rst_n,
  snes_pad_if.slave             pad,
  input  logic [SNES_NBITS-1:0] btn_in,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      bit_cnt,
  output logic                  busy
);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_lvl, clk_rise, clk_fall;
  logic unused_filt;

  snes_input_filter #(
    .FILT_LEN(FILT_LEN), .SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)
  ) u_latch_filt (
    .clk(clk_25M), .rst_n(rst_n), .din(pad.snes_latch),
    .level(latch_lvl), .rise(latch_rise), .fall(latch_fall)
  );

  snes_input_filter #(
    .FILT_LEN(FILT_LEN), .SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)
  ) u_clk_filt (
    .clk(clk_25M), .rst_n(rst_n), .din(pad.snes_clk),
    .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
  );

  assign unused_filt = ^{latch_rise, clk_lvl, clk_fall};

  logic [3:0]            state_q, state_d;
  logic [SNES_NBITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  data_q, data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  busy_q, busy_d;

  // Latch level overrides everything: reload every cycle, aborting any frame
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    data_d       = data_q;

    if (latch_lvl) begin
      state_d   = ST_LOADED;
      shreg_d   = btn_in;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_LOADED, ST_SHIFTING: begin
          if (state_q == ST_LOADED && latch_fall) begin
            state_d = ST_SHIFTING;
          end
          if (clk_rise) begin
            shreg_d   = {1'b0, shreg_q[SNES_NBITS-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_d == CNT_W'(SNES_NBITS)) begin
              state_d      = ST_DONE;
              frame_done_d = 1'b1;
              busy_d       = 1'b0;
            end
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end

    // Data is a registered function of the next state and shift register
    case (state_d)
      ST_IDLE: data_d = 1'b1;
      ST_DONE: data_d = 1'b0;
      default: data_d = ~shreg_d[0];
    endcase
  end

  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      data_q       <= 1'b1;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign pad.snes_data = data_q;
  assign frame_done    = frame_done_q;
  assign bit_cnt       = bit_cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_snes_pad_emulator.sv
// Self-checking bench: host model driving latch/clock at 25 MHz timing,
// table-driven frames plus abort, glitch, reset and btn_in-change sequences.
module tb_snes_pad_emulator;
  import snes_pad_emulator_pkg::*;

  localparam int HP        = 150;
  localparam int LATCH_CYC = 300;

  logic        clk_25M = 1'b0;
  logic        rst_n;
  logic [15:0] btn_in;
  logic        frame_done;
  logic [4:0]  bit_cnt;
  logic        busy;

  snes_pad_if pif ();

  snes_pad_emulator #(.FILT_LEN(4), .SYNC_STAGES(2)) dut (
    .clk_25M    (clk_25M),
    .rst_n      (rst_n),
    .pad        (pif.slave),
    .btn_in     (btn_in),
    .frame_done (frame_done),
    .bit_cnt    (bit_cnt),
    .busy       (busy)
  );

  always #20 clk_25M = ~clk_25M;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_total = 0;
  logic [4:0] fd_bitcnt = '0;
  logic       fd_busy   = 1'b1;

  always @(negedge clk_25M) begin
    if (frame_done) begin
      fd_total  = fd_total + 1;
      fd_bitcnt = bit_cnt;
      fd_busy   = busy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25M);
  endtask

  task automatic latch_pulse();
    pif.snes_latch = 1'b1;
    tick(LATCH_CYC);
    pif.snes_latch = 1'b0;
    tick(HP);
  endtask

  // Host samples data at each clock fall; the pad shifts on the rise
  task automatic clock_bits(input int n, output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      pif.snes_clk = 1'b0;
      if (i < 16) cap[i] = pif.snes_data;
      tick(HP);
      pif.snes_clk = 1'b1;
      tick(HP);
    end
  endtask

  typedef struct {
    logic [15:0] btn;
    logic [15:0] exp_bits;
  } vec_t;

  vec_t        vecs[4];
  logic [15:0] cap;
  int          fd0;

  initial begin
    vecs[0] = '{btn: 16'h0A5F, exp_bits: 16'hF5A0};
    vecs[1] = '{btn: 16'h0800, exp_bits: 16'hF7FF};
    vecs[2] = '{btn: 16'hFFF0, exp_bits: 16'h000F};
    vecs[3] = '{btn: 16'h0001, exp_bits: 16'hFFFE};

    rst_n          = 1'b0;
    btn_in         = 16'h0000;
    pif.snes_latch = 1'b0;
    pif.snes_clk   = 1'b1;
    tick(5);
    check("rst_data",       32'(pif.snes_data), 32'd1);
    check("rst_frame_done", 32'(frame_done),    32'd0);
    check("rst_bit_cnt",    32'(bit_cnt),       32'd0);
    check("rst_busy",       32'(busy),          32'd0);
    rst_n = 1'b1;
    tick(30);
    check("post_rst_data", 32'(pif.snes_data), 32'd1);
    check("post_rst_busy", 32'(busy),          32'd0);

    foreach (vecs[k]) begin
      btn_in = vecs[k].btn;
      fd0    = fd_total;
      latch_pulse();
      check("pre_shift_busy", 32'(busy),    32'd1);
      check("pre_shift_cnt",  32'(bit_cnt), 32'd0);
      clock_bits(16, cap);
      check("frame_bits",     32'(cap),            32'(vecs[k].exp_bits));
      check("frame_done_cnt", 32'(fd_total - fd0), 32'd1);
      check("fd_bit_cnt",     32'(fd_bitcnt),      32'd16);
      check("fd_busy",        32'(fd_busy),        32'd0);
      check("end_bit_cnt",    32'(bit_cnt),        32'd16);
      check("end_data",       32'(pif.snes_data),  32'd0);
    end

    // Clocks 17-20 after a complete 16'h0001 frame
    fd0 = fd_total;
    for (int i = 0; i < 4; i++) begin
      pif.snes_clk = 1'b0;
      check("extra_clk_data", 32'(pif.snes_data), 32'd0);
      tick(HP);
      pif.snes_clk = 1'b1;
      tick(HP);
    end
    check("extra_bit_cnt", 32'(bit_cnt),        32'd16);
    check("extra_no_fd",   32'(fd_total - fd0), 32'd0);

    // Abort after bit 7, then a full 16'h0800 frame
    btn_in = 16'h0A5F;
    fd0    = fd_total;
    latch_pulse();
    clock_bits(7, cap);
    check("abort_partial_bits", 32'(cap[6:0]), 32'h20);
    check("abort_bit_cnt_7",    32'(bit_cnt),  32'd7);
    btn_in         = 16'h0800;
    pif.snes_latch = 1'b1;
    tick(20);
    check("abort_bit_cnt_0", 32'(bit_cnt),        32'd0);
    check("abort_busy",      32'(busy),           32'd1);
    check("abort_no_fd",     32'(fd_total - fd0), 32'd0);
    check("abort_latch_data", 32'(pif.snes_data), 32'd1);
    tick(LATCH_CYC - 20);
    pif.snes_latch = 1'b0;
    tick(HP);
    clock_bits(16, cap);
    check("abort_next_bits", 32'(cap),            32'hF7FF);
    check("abort_next_fd",   32'(fd_total - fd0), 32'd1);

    // Short clock glitch rejected, 5-cycle pulse accepted
    btn_in = 16'h0000;
    latch_pulse();
    clock_bits(3, cap);
    check("glitch_pre_cnt", 32'(bit_cnt), 32'd3);
    pif.snes_clk = 1'b0;
    tick(3);
    pif.snes_clk = 1'b1;
    tick(30);
    check("glitch3_cnt", 32'(bit_cnt), 32'd3);
    pif.snes_clk = 1'b0;
    tick(5);
    pif.snes_clk = 1'b1;
    tick(30);
    check("pulse5_cnt", 32'(bit_cnt), 32'd4);

    // Reset at bit_cnt=9, then a 16'hFFF0 frame
    btn_in = 16'h0A5F;
    latch_pulse();
    clock_bits(9, cap);
    check("pre_rst_cnt", 32'(bit_cnt), 32'd9);
    rst_n = 1'b0;
    @(posedge clk_25M);
    #1;
    check("midrst_data",       32'(pif.snes_data), 32'd1);
    check("midrst_bit_cnt",    32'(bit_cnt),       32'd0);
    check("midrst_busy",       32'(busy),          32'd0);
    check("midrst_frame_done", 32'(frame_done),    32'd0);
    tick(3);
    rst_n  = 1'b1;
    tick(10);
    btn_in = 16'hFFF0;
    fd0    = fd_total;
    latch_pulse();
    clock_bits(16, cap);
    check("post_rst_bits", 32'(cap),            32'h000F);
    check("post_rst_fd",   32'(fd_total - fd0), 32'd1);

    // btn_in change just after the filtered latch fall is not seen this frame
    btn_in         = 16'h0000;
    fd0            = fd_total;
    pif.snes_latch = 1'b1;
    tick(LATCH_CYC);
    pif.snes_latch = 1'b0;
    tick(8);
    btn_in = 16'h0100;
    tick(HP - 8);
    clock_bits(16, cap);
    check("btn_change_bits", 32'(cap), 32'hFFFF);
    latch_pulse();
    clock_bits(16, cap);
    check("btn_next_bits", 32'(cap),            32'hFEFF);
    check("btn_change_fd", 32'(fd_total - fd0), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snes_pad_emulator.md
# snes_pad_emulator

Device-side SNES controller model: responds to a console or host's Latch/Clock pair and serialises a 16-bit button word onto the Data line. It is the counterpart of the SNES controller reader already in the design. Typical uses are closing the loop in hardware tests and presenting FPGA-generated input to a real console. It sits in the 25 MHz domain and takes both protocol inputs directly from pins.

## Interface
- `FILT_LEN`, default 4: consecutive identical synchronised samples required before a Latch/Clock level change is accepted (1–15).
- `SYNC_STAGES`, default 2: synchroniser flops per protocol input (≥2).
- `clk_25M`, input, 1: system clock, 25 MHz.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `snes_latch`, input, 1: Latch from host. Asynchronous.
- `snes_clk`, input, 1: serial clock from host. Asynchronous, idles high.
- `btn_in`, input, 16: button word, 1 = pressed. Bit 0 is serialised first (B); bits 12–15 are normally 0.
- `snes_data`, output, 1: serial data. Active-low: a pressed button drives 0.
- `frame_done`, output, 1: one-cycle pulse after the 16th bit has been shifted out.
- `bit_cnt`, output, 5: number of bits already shifted out of the current frame (0–16).
- `busy`, output, 1: high from latch capture until `frame_done` or reset.

## Operation
- Each of `snes_latch` and `snes_clk` passes through a `SNES_FILT` filter stage. The stage synchronises the input, requires a stable level, and produces a filtered level plus rise/fall pulses.
- Capture:
  - Every cycle in which filtered latch is high, load `shreg <= btn_in` and clear `bit_cnt` to 0.
  - This makes `snes_data = ~btn_in[0]` track the live `btn_in` while latch is high.
  - The value frozen on the latch fall is the frame value.
- Shift:
  - On a filtered clock rise while latch is low and `bit_cnt < 16`: `shreg <= {1'b0, shreg[15:1]}` and `bit_cnt <= bit_cnt + 1`.
  - `snes_data` always reflects `~shreg[0]` while in LOADED or SHIFTING.
- Host samples on the clock fall, so data only changes on the rise.
- State machine:
  - IDLE: `snes_data=1`.
  - IDLE→LOADED on filtered latch high.
  - LOADED→SHIFTING on latch fall.
  - SHIFTING: clock rise increments `bit_cnt`. The rise that makes `bit_cnt=16` moves to DONE and pulses `frame_done` in that cycle.
  - DONE: `snes_data=0`, matching a genuine pad after 16 bits. Further clock rises are ignored and `bit_cnt` saturates at 16.
  - DONE→LOADED on latch high.
- Latch rising in any state, including mid-SHIFTING, aborts the frame immediately and reloads. No `frame_done` is generated for an aborted frame.
- Clock edges while latch is high are ignored; there is no shift during latch.
- Filter rejects pulses shorter than `FILT_LEN` cycles.

## Timing
- Reset values: `snes_data=1`, `frame_done=0`, `bit_cnt=0`, `busy=0`, state=IDLE.
- Filter internals reset to input-idle levels: latch=0, clock=1. This prevents a spurious edge when coming out of reset.
- Pin-to-action latency: `SYNC_STAGES + FILT_LEN + 1` cycles, which is 7 cycles (280 ns) at defaults.
  - Applies from a latch/clock pin edge to the resulting `snes_data` update.
  - This must stay below half the host's 6 µs half-period (150 cycles).
- `frame_done` is asserted for exactly 1 cycle, registered together with `bit_cnt=16`. `busy` falls in that same cycle.
- `btn_in` may change at any time. Changes are seen within 1 cycle while latch is high and are ignored otherwise.
- A reset asserted mid-frame takes effect on the next clock edge. It returns the block to IDLE with `snes_data=1`.

## Structure
- Shared include `snes_defs.vh` holds:
  - state encodings (one-hot, 4 bits: IDLE, LOADED, SHIFTING, DONE)
  - `SNES_NBITS = 16`
  - button bit-index constants (B=0, Y=1, SEL=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11)
  - the 25 MHz 6 µs/12 µs delay constants (150/300), shared with the reader.
- One sub-module, `snes_input_filter`: synchroniser, stability counter, filtered level, `rise` and `fall` pulses. It is instantiated twice.

## Test plan
- Host model at 25 MHz: latch high 300 cycles, then 16 clock periods of 150 low / 150 high, sampling on the fall.
  - With `btn_in=16'h0A5F`, the 16 bits captured are the active-low serial image of `16'h0A5F`.
  - `frame_done` pulses once and `bit_cnt=16`.
- With `btn_in=16'h0001` after the full frame, extra clocks 17–20 read `snes_data=0` and `bit_cnt` stays at 16.
- Re-latch after bit 7 of a frame:
  - `bit_cnt` returns to 0, and no `frame_done` is produced for the aborted frame.
  - The next full frame with `btn_in=16'h0800` returns correct data.
- A 3-cycle glitch on `snes_clk` with `FILT_LEN=4` produces no shift and no change in `bit_cnt`. A 5-cycle pulse shifts exactly once.
- Assert `rst_n=0` at `bit_cnt=9`: on the next edge all outputs take reset values, and a following frame with `btn_in=16'hFFF0` reads correctly.
- Change `btn_in` from `16'h0000` to `16'h0100` one cycle after latch falls: the frame reads all-released, and the next frame shows A pressed.
